// File: rtl/irq_line_driver.sv
// Collects per-source event pulses into pending/overrun bits and drives one level
// interrupt line with a guaranteed minimum low time between assertions.
module irq_line_driver #(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned MIN_LOW = 4
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic [NUM_SRC-1:0] evt_i,
  input  logic [NUM_SRC-1:0] en_i,
  input  logic               clr_we_i,
  input  logic [NUM_SRC-1:0] clr_mask_i,
  output logic [NUM_SRC-1:0] pending_o,
  output logic [NUM_SRC-1:0] overrun_o,
  output logic               irq_o
);

  localparam int unsigned CNT_W = $clog2(MIN_LOW + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(MIN_LOW - 1);

  // ASSERT is the only encoding that drives the line high. Every transition into
  // or out of it passes only through states that decode to 0, so irq_o is glitch-free.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ASSERT  = 2'b01,
    HOLDOFF = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_SRC-1:0] pending_q, overrun_q;
  logic [NUM_SRC-1:0] clr_c;
  logic               active_c;

  assign clr_c    = {NUM_SRC{clr_we_i}} & clr_mask_i;
  assign active_c = |(pending_q & en_i);

  // Event capture: a new event always wins over a coincident clear.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      pending_q <= evt_i | (pending_q & ~clr_c);
      overrun_q <= (evt_i & pending_q) | (overrun_q & ~clr_c);
    end
  end

  assign pending_o = pending_q;
  assign overrun_o = overrun_q;

  // State register and holdoff counter.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; active is ignored in HOLDOFF until the counter expires.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (active_c) begin
          state_d = ASSERT;
        end
      end
      ASSERT: begin
        if (!active_c) begin
          state_d = HOLDOFF;
          cnt_d   = HOLD_LOAD;
        end
      end
      HOLDOFF: begin
        if (cnt_q == '0) begin
          state_d = active_c ? ASSERT : IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Line decode straight from the state flops.
  always_comb begin
    irq_o = 1'b0;
    if (state_q == ASSERT) begin
      irq_o = 1'b1;
    end
  end

endmodule

// File: tb/tb_irq_line_driver.sv
// Directed vector bench for irq_line_driver (NUM_SRC=8, MIN_LOW=4).
module tb_irq_line_driver;

  logic       aclk;
  logic       areset;
  logic [7:0] evt_i;
  logic [7:0] en_i;
  logic       clr_we_i;
  logic [7:0] clr_mask_i;
  logic [7:0] pending_o;
  logic [7:0] overrun_o;
  logic       irq_o;

  int n_cmp;
  int n_fail;

  irq_line_driver #(.NUM_SRC(8), .MIN_LOW(4)) dut (
    .aclk       (aclk),
    .areset     (areset),
    .evt_i      (evt_i),
    .en_i       (en_i),
    .clr_we_i   (clr_we_i),
    .clr_mask_i (clr_mask_i),
    .pending_o  (pending_o),
    .overrun_o  (overrun_o),
    .irq_o      (irq_o)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [7:0] evt;
    logic [7:0] en;
    logic       cw;
    logic [7:0] cm;
    logic [7:0] pend;
    logic [7:0] ovr;
    logic       irq;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [7:0] evt, input logic [7:0] en, input logic cw,
                              input logic [7:0] cm, input logic [7:0] pend,
                              input logic [7:0] ovr, input logic irq);
    vec_t v;
    v.evt = evt; v.en = en; v.cw = cw; v.cm = cm;
    v.pend = pend; v.ovr = ovr; v.irq = irq;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive inputs just after a rising edge, then sample outputs at the falling edge.
  task automatic cyc(input logic [7:0] evt, input logic [7:0] en, input logic cw,
                     input logic [7:0] cm);
    @(posedge aclk);
    #1;
    evt_i = evt; en_i = en; clr_we_i = cw; clr_mask_i = cm;
    @(negedge aclk);
  endtask

  task automatic chk_all(input string nm, input logic [7:0] pend, input logic [7:0] ovr,
                         input logic irq);
    chk({nm, " pending"}, 32'(pending_o), 32'(pend));
    chk({nm, " overrun"}, 32'(overrun_o), 32'(ovr));
    chk({nm, " irq"}, 32'(irq_o), 32'(irq));
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    areset = 1'b1;
    evt_i = '0; en_i = '0; clr_we_i = 1'b0; clr_mask_i = '0;

    // Each row: inputs applied this cycle, outputs as observed during the same cycle.
    //                 evt    en    cw    cm     pend   ovr   irq
    tbl.push_back(mk(8'h00, 8'h01, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0));
    tbl.push_back(mk(8'h01, 8'h01, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0)); // event N
    tbl.push_back(mk(8'h00, 8'h01, 1'b0, 8'h00, 8'h01, 8'h00, 1'b0)); // pending N+1
    tbl.push_back(mk(8'h01, 8'h01, 1'b0, 8'h00, 8'h01, 8'h00, 1'b1)); // irq N+2, repeat evt
    tbl.push_back(mk(8'h00, 8'h01, 1'b0, 8'h00, 8'h01, 8'h01, 1'b1)); // overrun
    tbl.push_back(mk(8'h00, 8'h01, 1'b1, 8'h01, 8'h01, 8'h01, 1'b1)); // clear
    tbl.push_back(mk(8'h00, 8'h01, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1));
    tbl.push_back(mk(8'h01, 8'h01, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0)); // fall M, event
    tbl.push_back(mk(8'h00, 8'h01, 1'b0, 8'h00, 8'h01, 8'h00, 1'b0));
    tbl.push_back(mk(8'h00, 8'h01, 1'b0, 8'h00, 8'h01, 8'h00, 1'b0));
    tbl.push_back(mk(8'h00, 8'h01, 1'b0, 8'h00, 8'h01, 8'h00, 1'b0));
    tbl.push_back(mk(8'h08, 8'h09, 1'b0, 8'h00, 8'h01, 8'h00, 1'b1)); // rise M+4
    tbl.push_back(mk(8'h08, 8'h09, 1'b1, 8'h08, 8'h09, 8'h00, 1'b1)); // set/clear collision
    tbl.push_back(mk(8'h00, 8'h09, 1'b1, 8'h09, 8'h09, 8'h08, 1'b1));
    tbl.push_back(mk(8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1));
    tbl.push_back(mk(8'h80, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0)); // masked event
    tbl.push_back(mk(8'h00, 8'h00, 1'b0, 8'h00, 8'h80, 8'h00, 1'b0));
    tbl.push_back(mk(8'h00, 8'h00, 1'b0, 8'h00, 8'h80, 8'h00, 1'b0));
    tbl.push_back(mk(8'h00, 8'h00, 1'b0, 8'h00, 8'h80, 8'h00, 1'b0));
    tbl.push_back(mk(8'h00, 8'h80, 1'b0, 8'h00, 8'h80, 8'h00, 1'b0)); // enable rise N
    tbl.push_back(mk(8'h00, 8'h80, 1'b0, 8'h00, 8'h80, 8'h00, 1'b1)); // irq N+1
    tbl.push_back(mk(8'h00, 8'h00, 1'b0, 8'h00, 8'h80, 8'h00, 1'b1)); // disable in ASSERT
    tbl.push_back(mk(8'h00, 8'h80, 1'b0, 8'h00, 8'h80, 8'h00, 1'b0)); // holdoff ignores active
    tbl.push_back(mk(8'h00, 8'h80, 1'b0, 8'h00, 8'h80, 8'h00, 1'b0));
    tbl.push_back(mk(8'h00, 8'h80, 1'b0, 8'h00, 8'h80, 8'h00, 1'b0));
    tbl.push_back(mk(8'h00, 8'h80, 1'b0, 8'h00, 8'h80, 8'h00, 1'b0));
    tbl.push_back(mk(8'h00, 8'h80, 1'b1, 8'h80, 8'h80, 8'h00, 1'b1));
    tbl.push_back(mk(8'h00, 8'h80, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1));
    tbl.push_back(mk(8'h00, 8'h80, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0));
    tbl.push_back(mk(8'h00, 8'h80, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0));
    tbl.push_back(mk(8'h00, 8'h80, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0));
    tbl.push_back(mk(8'h00, 8'h80, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0));
    tbl.push_back(mk(8'h00, 8'h80, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0)); // back in IDLE

    repeat (2) @(negedge aclk);
    chk_all("reset", 8'h00, 8'h00, 1'b0);
    @(posedge aclk);
    #1;
    areset = 1'b0;

    foreach (tbl[i]) begin
      cyc(tbl[i].evt, tbl[i].en, tbl[i].cw, tbl[i].cm);
      chk_all($sformatf("row%0d", i), tbl[i].pend, tbl[i].ovr, tbl[i].irq);
    end

    // Multi-source: clearing one of two pending sources must not cause holdoff.
    cyc(8'h06, 8'h06, 1'b0, 8'h00);
    cyc(8'h00, 8'h06, 1'b0, 8'h00);
    chk_all("multi set", 8'h06, 8'h00, 1'b0);
    cyc(8'h00, 8'h06, 1'b1, 8'h02);
    chk_all("multi rise", 8'h06, 8'h00, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cyc(8'h00, 8'h06, 1'b0, 8'h00);
      chk_all($sformatf("multi hold%0d", k), 8'h04, 8'h00, 1'b1);
    end
    cyc(8'h00, 8'h06, 1'b1, 8'h04);
    chk_all("multi clr2", 8'h04, 8'h00, 1'b1);
    cyc(8'h00, 8'h06, 1'b0, 8'h00);
    chk_all("multi clr2+1", 8'h00, 8'h00, 1'b1);
    cyc(8'h00, 8'h06, 1'b0, 8'h00);
    chk_all("multi clr2+2", 8'h00, 8'h00, 1'b0);
    repeat (4) cyc(8'h00, 8'h00, 1'b0, 8'h00);

    // Async reset in the middle of ASSERT with an overrun flagged.
    cyc(8'h01, 8'h01, 1'b0, 8'h00);
    cyc(8'h01, 8'h01, 1'b0, 8'h00);
    cyc(8'h00, 8'h01, 1'b0, 8'h00);
    chk_all("pre-reset", 8'h01, 8'h01, 1'b1);
    #1;
    areset = 1'b1;
    #1;
    chk_all("async reset", 8'h00, 8'h00, 1'b0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    chk_all("post-reset", 8'h00, 8'h00, 1'b0);
    cyc(8'h01, 8'h01, 1'b0, 8'h00);
    chk_all("idle evt", 8'h00, 8'h00, 1'b0);
    cyc(8'h00, 8'h01, 1'b0, 8'h00);
    chk_all("idle evt+1", 8'h01, 8'h00, 1'b0);
    cyc(8'h00, 8'h01, 1'b0, 8'h00);
    chk_all("idle evt+2", 8'h01, 8'h00, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
